// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the raster timing generator: FSM state encoding,
// standard mode timing sets for top-level parameter overrides and a sync
// level helper.
package video_timing_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vtg_state_e;

  typedef struct packed {
    int h_act;
    int h_fp;
    int h_pw;
    int h_bp;
    int v_act;
    int v_fp;
    int v_pw;
    int v_bp;
  } vtg_mode_t;

  // Industry-standard 640x480@60 VGA timing
  localparam vtg_mode_t VTG_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
  // Typical 800x480 TFT panel timing
  localparam vtg_mode_t VTG_800X480 = '{800, 40, 48, 88, 480, 13, 3, 32};

  // Map a sync "asserted" flag onto the pin level for the given polarity
  function automatic logic vtg_sync_lvl(input logic act, input logic pol);
    return act ? pol : !pol;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing generator output bundle. The master side is the generator, the
// slave side is the renderer/output stage that drives the run request.
// VTG_FRAME_CNT_EN adds the completed-frame counter.
interface video_timing_gen_if #(
  parameter int CW = 12
);
  logic          en;
  logic [CW-1:0] sx;
  logic [CW-1:0] sy;
  logic [CW-1:0] lx;
  logic [CW-1:0] ly;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          busy;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]   frame_cnt;

  modport master (input en, output sx, sy, lx, ly, hsync, vsync, de,
                  line_start, frame_start, busy, frame_cnt);
  modport slave  (output en, input sx, sy, lx, ly, hsync, vsync, de,
                  line_start, frame_start, busy, frame_cnt);
`else
  modport master (input en, output sx, sy, lx, ly, hsync, vsync, de,
                  line_start, frame_start, busy);
  modport slave  (output en, input sx, sy, lx, ly, hsync, vsync, de,
                  line_start, frame_start, busy);
`endif
endinterface

// File: rtl/video_timing_gen_delay.sv
// vtg_delay_line: DEPTH-stage register delay with synchronous active-low
// reset to a per-bit value. DEPTH=0 is a straight wire.
module vtg_delay_line #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] r_pipe;

      // Shift register; reset parks every stage at its idle value
      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          r_pipe <= {DEPTH{RST_VAL}};
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with run/stop
// control, frame-aligned stopping, logical (shifted) coordinates and a
// delay line on the sync/strobe path.
// Optional feature macro: VTG_FRAME_CNT_EN (16-bit completed-frame counter).
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACT      = VTG_640X480.h_act,
  parameter int H_FP       = VTG_640X480.h_fp,
  parameter int H_PW       = VTG_640X480.h_pw,
  parameter int H_BP       = VTG_640X480.h_bp,
  parameter int V_ACT      = VTG_640X480.v_act,
  parameter int V_FP       = VTG_640X480.v_fp,
  parameter int V_PW       = VTG_640X480.v_pw,
  parameter int V_BP       = VTG_640X480.v_bp,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int CW         = 12,
  parameter int SCALE_LOG2 = 0,
  parameter int PIPE_DLY   = 0
) (
  input  logic                pix_clk,
  input  logic                pix_rstn,
  video_timing_gen_if.master  vtg
);

  localparam int LINE  = H_ACT + H_FP + H_PW + H_BP;
  localparam int FRAME = V_ACT + V_FP + V_PW + V_BP;

  // Inclusive bounds keep every constant below LINE/FRAME so they fit CW
  localparam logic [CW-1:0] SX_LAST  = CW'(LINE - 1);
  localparam logic [CW-1:0] SY_LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] HA_LAST  = CW'(H_ACT - 1);
  localparam logic [CW-1:0] VA_LAST  = CW'(V_ACT - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACT + H_FP + H_PW - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACT + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACT + V_FP + V_PW - 1);

  // {hsync, vsync, de, line_start, frame_start} while idle
  localparam logic [4:0] RAW_IDLE = {!H_POL, !V_POL, 3'b000};

  vtg_state_e    r_state;
  logic [CW-1:0] r_sx;
  logic [CW-1:0] r_sy;

  logic          w_scan;
  logic          w_eol;
  logic          w_last;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_de;
  logic          w_ls;
  logic          w_fs;
  logic [4:0]    w_raw;
  logic [4:0]    w_dly;

  assign w_scan = (r_state != ST_IDLE);
  assign w_eol  = (r_sx == SX_LAST);
  assign w_last = w_eol && (r_sy == SY_LAST);

  // Run/stop FSM and raster counters. A stop request taken on the very last
  // pixel of a frame lands directly in IDLE, so the frame never restarts.
  always_ff @(posedge pix_clk) begin
    if (!pix_rstn) begin
      r_state <= ST_IDLE;
      r_sx    <= '0;
      r_sy    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (vtg.en) r_state <= ST_RUN;
        end
        ST_RUN, ST_STOP: begin
          r_sx <= w_eol ? '0 : r_sx + CW'(1);
          if (w_eol) r_sy <= (r_sy == SY_LAST) ? '0 : r_sy + CW'(1);
          if (r_state == ST_STOP || !vtg.en)
            r_state <= w_last ? ST_IDLE : ST_STOP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Raw decode; everything idles while the counters are parked
  assign w_hs_act = w_scan && (r_sx >= HS_FIRST) && (r_sx <= HS_LAST);
  assign w_vs_act = w_scan && (r_sy >= VS_FIRST) && (r_sy <= VS_LAST);
  assign w_de     = w_scan && (r_sx <= HA_LAST) && (r_sy <= VA_LAST);
  assign w_ls     = w_scan && (r_sx == '0);
  assign w_fs     = w_ls && (r_sy == '0);

  assign w_raw = {vtg_sync_lvl(w_hs_act, H_POL), vtg_sync_lvl(w_vs_act, V_POL),
                  w_de, w_ls, w_fs};

  vtg_delay_line #(
    .W       (5),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (RAW_IDLE)
  ) u_dly (
    .i_clk  (pix_clk),
    .i_rstn (pix_rstn),
    .i_d    (w_raw),
    .o_q    (w_dly)
  );

  assign vtg.sx          = r_sx;
  assign vtg.sy          = r_sy;
  assign vtg.lx          = r_sx >> SCALE_LOG2;
  assign vtg.ly          = r_sy >> SCALE_LOG2;
  assign vtg.hsync       = w_dly[4];
  assign vtg.vsync       = w_dly[3];
  assign vtg.de          = w_dly[2];
  assign vtg.line_start  = w_dly[1];
  assign vtg.frame_start = w_dly[0];
  assign vtg.busy        = w_scan;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] r_fcnt;

  // Count frames as the counters leave the last pixel; wraps naturally
  always_ff @(posedge pix_clk) begin
    if (!pix_rstn)            r_fcnt <= '0;
    else if (w_scan && w_last) r_fcnt <= r_fcnt + 16'd1;
  end

  assign vtg.frame_cnt = r_fcnt;
`endif

endmodule
